// File: rtl/cluster_truncator.sv
// Cluster truncation stage: latches a cluster vector on load and removes its
// highest-priority set bit every clock, with a per-frame cluster limit.
module cluster_truncator #(
  parameter int MXBITS    = 768,
  parameter int MXSEGS    = 12,
  parameter int MXPOPS    = 16,
  parameter int MSB_FIRST = 0,
  parameter int CNTW      = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load,
  input  logic [MXBITS-1:0] vpfs_in,
  output logic [MXBITS-1:0] vpfs_out,
  output logic              empty,
  output logic              overflow
);

  localparam int              SEGW = MXBITS / MXSEGS;
  localparam logic [CNTW-1:0] POPS = CNTW'(MXPOPS);

  logic [MXBITS-1:0] s;
  logic [MXBITS-1:0] src;
  logic [MXBITS-1:0] fwd;
  logic [MXBITS-1:0] core;
  logic [MXBITS-1:0] trunc_v;
  logic [CNTW-1:0]   cnt;
  logic [CNTW-1:0]   cnt_inc;

  // A load bypasses the register so the first cluster appears in the load cycle.
  assign src      = load ? vpfs_in : s;
  assign vpfs_out = reset ? '0 : src;
  assign empty    = ~|vpfs_out;
  assign cnt_inc  = cnt + 1'b1;

  // MSB-first order runs the same LSB-first core on the bit-reversed vector.
  // NOTE: every variable gets a default before any conditional write, so no latch is inferred.
  always_comb begin : trunc_logic
    logic [SEGW-1:0] seg;
    logic            keep;
    fwd     = src;
    core    = '0;
    trunc_v = '0;
    keep    = 1'b0;
    seg     = '0;
    if (MSB_FIRST != 0) begin
      for (int b = 0; b < MXBITS; b++) fwd[b] = src[MXBITS-1-b];
    end
    // Only the lowest active segment loses a bit; keep latches once any lower segment is active.
    for (int i = 0; i < MXSEGS; i++) begin
      seg                    = fwd[i*SEGW +: SEGW];
      core[i*SEGW +: SEGW]   = keep ? seg : (seg & ~(-seg));
      keep                   = keep | (|seg);
    end
    trunc_v = core;
    if (MSB_FIRST != 0) begin
      for (int b = 0; b < MXBITS; b++) trunc_v[b] = core[MXBITS-1-b];
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      s        <= '0;
      cnt      <= POPS;
      overflow <= 1'b0;
    end else if (load) begin
      cnt <= 1;
      if (MXPOPS == 1) begin
        s        <= '0;
        overflow <= |trunc_v;
      end else begin
        s        <= trunc_v;
        overflow <= 1'b0;
      end
    end else if (cnt < POPS) begin
      cnt <= cnt_inc;
      // Last presentation of the frame: anything still left is an overflow.
      if (cnt_inc == POPS) begin
        s        <= '0;
        overflow <= |trunc_v;
      end else begin
        s <= trunc_v;
      end
    end
  end

endmodule
